// File: rtl/rx_deser_unit_if.sv
// ============================================================================
// Module : rx_deser_unit_if
// Brief  : Bit-strobe input and word valid/ready output bundle of rx_deser_unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface rx_deser_unit_if #(
  parameter int DATA_W = 8
);
  logic              clr;
  logic              bit_vld;
  logic              sampled_bit;
  logic              msb_first;
  logic              par_typ;
  logic              data_rdy;
  logic [DATA_W-1:0] P_DATA;
  logic              data_vld;
  logic              par_err;
  logic              ovr_err;
  logic              busy;

  // Sampler/consumer side
  modport master (
    output clr, bit_vld, sampled_bit, msb_first, par_typ, data_rdy,
    input  P_DATA, data_vld, par_err, ovr_err, busy
  );

  // Deserializer side
  modport slave (
    input  clr, bit_vld, sampled_bit, msb_first, par_typ, data_rdy,
    output P_DATA, data_vld, par_err, ovr_err, busy
  );
endinterface

`default_nettype wire

// File: rtl/rx_deser_unit.sv
// ============================================================================
// Module : rx_deser_unit
// Brief  : UART receive serial-to-parallel collector with selectable bit order,
//          optional parity (macro DESER_PARITY_EN) and a valid/ready hold stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rx_deser_unit #(
  parameter int DATA_W = 8
) (
  input  wire logic          CLK,
  input  wire logic          RST_n,
  rx_deser_unit_if.slave     bus
);

`ifdef DESER_PARITY_EN
  localparam int FRAME_LEN = DATA_W + 1;
`else
  localparam int FRAME_LEN = DATA_W;
`endif
  localparam int CW = $clog2(DATA_W + 2);

  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_sh;
  logic              r_ord;
  logic [DATA_W-1:0] r_pdata;
  logic              r_vld;
  logic              r_perr;
  logic              r_ovr;

  logic              w_first;
  logic              w_ord;
  logic [CW-1:0]     w_idx;
  logic [DATA_W-1:0] w_sh_base;
  logic [DATA_W-1:0] w_sh_next;
  logic              w_last;
  logic              w_take;
  logic              w_done;
  logic              w_load;
  logic              w_drop;
  logic              w_is_data;
  logic [DATA_W-1:0] w_word;
  logic              w_err;

  // The first strobe of a frame uses live msb_first and a cleared shift register.
  always_comb begin
    w_first   = (r_cnt == '0);
    w_ord     = w_first ? bus.msb_first : r_ord;
    w_idx     = w_ord ? (CW'(DATA_W - 1) - r_cnt) : r_cnt;
    w_sh_base = w_first ? '0 : r_sh;
    w_sh_next = w_sh_base;
    for (int i = 0; i < DATA_W; i++) begin
      if (w_idx == CW'(i)) begin
        w_sh_next[i] = bus.sampled_bit;
      end
    end
    w_last = (r_cnt == CW'(FRAME_LEN - 1));
    w_take = bus.bit_vld && !bus.clr;
    w_done = w_take && w_last;
    w_load = w_done && (!r_vld || bus.data_rdy);
    w_drop = w_done && !w_load;
  end

`ifdef DESER_PARITY_EN
  logic r_acc;
  logic w_acc_next;

  // On the parity strobe the data word is already complete in r_sh.
  always_comb begin
    w_is_data  = (r_cnt < CW'(DATA_W));
    w_acc_next = (w_first ? 1'b0 : r_acc) ^ bus.sampled_bit;
    w_word     = r_sh;
    w_err      = r_acc ^ bus.sampled_bit ^ bus.par_typ;
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_acc <= 1'b0;
    end else if (bus.clr) begin
      r_acc <= 1'b0;
    end else if (bus.bit_vld && w_is_data) begin
      r_acc <= w_acc_next;
    end
  end
`else
  logic w_unused_par_typ;

  // The last data strobe completes the frame, so the word bypasses r_sh.
  always_comb begin
    w_is_data        = 1'b1;
    w_word           = w_sh_next;
    w_err            = 1'b0;
    w_unused_par_typ = bus.par_typ;
  end
`endif

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_cnt <= '0;
      r_sh  <= '0;
      r_ord <= 1'b0;
    end else if (bus.clr) begin
      r_cnt <= '0;
      r_sh  <= '0;
    end else if (bus.bit_vld) begin
      r_cnt <= w_last ? '0 : (r_cnt + CW'(1));
      if (w_first) begin
        r_ord <= bus.msb_first;
      end
      if (w_is_data) begin
        r_sh <= w_sh_next;
      end
    end
  end

  // Holding stage: a new word may replace a consumed one on the same edge.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_pdata <= '0;
      r_vld   <= 1'b0;
      r_perr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= w_drop;
      if (w_load) begin
        r_pdata <= w_word;
        r_perr  <= w_err;
        r_vld   <= 1'b1;
      end else if (r_vld && bus.data_rdy) begin
        r_vld <= 1'b0;
      end
    end
  end

  assign bus.P_DATA   = r_pdata;
  assign bus.data_vld = r_vld;
  assign bus.par_err  = r_perr;
  assign bus.ovr_err  = r_ovr;
  assign bus.busy     = (r_cnt != '0);

endmodule

`default_nettype wire

// File: tb/tb_rx_deser_unit.sv
// ============================================================================
// Module : tb_rx_deser_unit
// Brief  : Directed self-checking bench for rx_deser_unit (DATA_W = 8).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rx_deser_unit;

  localparam int DW = 8;
`ifdef DESER_PARITY_EN
  localparam int FL = DW + 1;
`else
  localparam int FL = DW;
`endif

  logic CLK;
  logic RST_n;
  int   n_pass;
  int   n_total;

  rx_deser_unit_if #(.DATA_W(DW)) bus ();

  rx_deser_unit #(.DATA_W(DW)) u_dut (
    .CLK   (CLK),
    .RST_n (RST_n),
    .bus   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Bits go out bits[0] first; the parity bit follows when enabled.
  task automatic send_frame(input logic [15:0] bits, input logic pbit,
                            input int flip_at, input logic rdy_last);
    for (int k = 0; k < FL; k++) begin
      @(negedge CLK);
      if (k == flip_at) bus.msb_first = ~bus.msb_first;
      bus.bit_vld     = 1'b1;
      bus.sampled_bit = (k < DW) ? bits[k] : pbit;
      bus.data_rdy    = rdy_last && (k == FL - 1);
    end
    @(negedge CLK);
    bus.bit_vld  = 1'b0;
    bus.data_rdy = 1'b0;
  endtask

  task automatic consume();
    @(negedge CLK);
    bus.data_rdy = 1'b1;
    @(negedge CLK);
    bus.data_rdy = 1'b0;
    n_total++;
    if (bus.data_vld !== 1'b0)
      $display("FAIL consume_vld: got %b want 0", bus.data_vld);
    else n_pass++;
  endtask

  task automatic test_reset();
    RST_n = 1'b0;
    repeat (2) @(negedge CLK);
    n_total++;
    if (bus.P_DATA !== 8'h00) $display("FAIL rst_pdata: got %h want 00", bus.P_DATA); else n_pass++;
    n_total++;
    if (bus.data_vld !== 1'b0) $display("FAIL rst_vld: got %b want 0", bus.data_vld); else n_pass++;
    n_total++;
    if (bus.par_err !== 1'b0) $display("FAIL rst_perr: got %b want 0", bus.par_err); else n_pass++;
    n_total++;
    if (bus.ovr_err !== 1'b0) $display("FAIL rst_ovr: got %b want 0", bus.ovr_err); else n_pass++;
    n_total++;
    if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy); else n_pass++;
    RST_n = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_lsb_first();
    bus.msb_first = 1'b0;
    @(negedge CLK);
    bus.bit_vld = 1'b1; bus.sampled_bit = 1'b1;
    @(negedge CLK);
    bus.bit_vld = 1'b0;
    n_total++;
    if (bus.busy !== 1'b1) $display("FAIL lsb_busy_mid: got %b want 1", bus.busy); else n_pass++;
    bus.clr = 1'b1;
    @(negedge CLK);
    bus.clr = 1'b0;
    send_frame(16'h004D, 1'b0, -1, 1'b0);
    n_total++;
    if (bus.P_DATA !== 8'h4D) $display("FAIL lsb_pdata: got %h want 4d", bus.P_DATA); else n_pass++;
    n_total++;
    if (bus.data_vld !== 1'b1) $display("FAIL lsb_vld: got %b want 1", bus.data_vld); else n_pass++;
    n_total++;
    if (bus.busy !== 1'b0) $display("FAIL lsb_busy_end: got %b want 0", bus.busy); else n_pass++;
    n_total++;
    if (bus.par_err !== 1'b0) $display("FAIL lsb_perr: got %b want 0", bus.par_err); else n_pass++;
    @(negedge CLK);
    n_total++;
    if (bus.data_vld !== 1'b1) $display("FAIL lsb_vld_hold: got %b want 1", bus.data_vld); else n_pass++;
    consume();
  endtask

  task automatic test_msb_first();
    bus.msb_first = 1'b1;
    send_frame(16'h004D, 1'b0, -1, 1'b0);
    n_total++;
    if (bus.P_DATA !== 8'hB2) $display("FAIL msb_pdata: got %h want b2", bus.P_DATA); else n_pass++;
    consume();
    send_frame(16'h004D, 1'b0, 3, 1'b0);
    n_total++;
    if (bus.P_DATA !== 8'hB2) $display("FAIL msb_flip_pdata: got %h want b2", bus.P_DATA); else n_pass++;
    consume();
    bus.msb_first = 1'b0;
  endtask

`ifdef DESER_PARITY_EN
  task automatic test_parity();
    bus.par_typ = 1'b0;
    send_frame(16'h004D, 1'b0, -1, 1'b0);
    n_total++;
    if (bus.par_err !== 1'b0) $display("FAIL par_even_ok: got %b want 0", bus.par_err); else n_pass++;
    consume();
    send_frame(16'h004D, 1'b1, -1, 1'b0);
    n_total++;
    if (bus.par_err !== 1'b1) $display("FAIL par_even_bad: got %b want 1", bus.par_err); else n_pass++;
    consume();
    bus.par_typ = 1'b1;
    send_frame(16'h004D, 1'b1, -1, 1'b0);
    n_total++;
    if (bus.par_err !== 1'b0) $display("FAIL par_odd_ok: got %b want 0", bus.par_err); else n_pass++;
    n_total++;
    if (bus.P_DATA !== 8'h4D) $display("FAIL par_pdata: got %h want 4d", bus.P_DATA); else n_pass++;
    consume();
    bus.par_typ = 1'b0;
  endtask
`endif

  task automatic test_overrun();
    send_frame(16'h004D, 1'b0, -1, 1'b0);
    send_frame(16'h0012, 1'b0, -1, 1'b0);
    n_total++;
    if (bus.ovr_err !== 1'b1) $display("FAIL ovr_pulse: got %b want 1", bus.ovr_err); else n_pass++;
    n_total++;
    if (bus.P_DATA !== 8'h4D) $display("FAIL ovr_pdata: got %h want 4d", bus.P_DATA); else n_pass++;
    n_total++;
    if (bus.data_vld !== 1'b1) $display("FAIL ovr_vld: got %b want 1", bus.data_vld); else n_pass++;
    @(negedge CLK);
    n_total++;
    if (bus.ovr_err !== 1'b0) $display("FAIL ovr_one_cycle: got %b want 0", bus.ovr_err); else n_pass++;
    send_frame(16'h0012, 1'b0, -1, 1'b1);
    n_total++;
    if (bus.P_DATA !== 8'h12) $display("FAIL b2b_pdata: got %h want 12", bus.P_DATA); else n_pass++;
    n_total++;
    if (bus.data_vld !== 1'b1) $display("FAIL b2b_vld: got %b want 1", bus.data_vld); else n_pass++;
    n_total++;
    if (bus.ovr_err !== 1'b0) $display("FAIL b2b_ovr: got %b want 0", bus.ovr_err); else n_pass++;
    consume();
  endtask

  task automatic test_clr();
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      bus.bit_vld = 1'b1; bus.sampled_bit = 1'b1;
    end
    @(negedge CLK);
    bus.bit_vld = 1'b0; bus.clr = 1'b1;
    @(negedge CLK);
    bus.clr = 1'b0;
    n_total++;
    if (bus.busy !== 1'b0) $display("FAIL clr_busy: got %b want 0", bus.busy); else n_pass++;
    n_total++;
    if (bus.data_vld !== 1'b0) $display("FAIL clr_no_word: got %b want 0", bus.data_vld); else n_pass++;
    send_frame(16'h00A5, 1'b0, -1, 1'b0);
    n_total++;
    if (bus.P_DATA !== 8'hA5) $display("FAIL clr_pdata: got %h want a5", bus.P_DATA); else n_pass++;
    consume();
    @(negedge CLK);
    bus.bit_vld = 1'b1; bus.sampled_bit = 1'b1; bus.clr = 1'b1;
    @(negedge CLK);
    bus.bit_vld = 1'b0; bus.clr = 1'b0;
    n_total++;
    if (bus.busy !== 1'b0) $display("FAIL clr_bit_busy: got %b want 0", bus.busy); else n_pass++;
    send_frame(16'h005A, 1'b0, -1, 1'b0);
    n_total++;
    if (bus.P_DATA !== 8'h5A) $display("FAIL clr_bit_pdata: got %h want 5a", bus.P_DATA); else n_pass++;
  endtask

  // Entered with 0x5A still held, so the reset must clear a live word.
  task automatic test_reset_midframe();
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      bus.bit_vld = 1'b1; bus.sampled_bit = k[0];
    end
    @(negedge CLK);
    bus.bit_vld = 1'b0;
    #2 RST_n = 1'b0;
    #1;
    n_total++;
    if (bus.P_DATA !== 8'h00) $display("FAIL rstm_pdata: got %h want 00", bus.P_DATA); else n_pass++;
    n_total++;
    if (bus.data_vld !== 1'b0) $display("FAIL rstm_vld: got %b want 0", bus.data_vld); else n_pass++;
    n_total++;
    if (bus.busy !== 1'b0) $display("FAIL rstm_busy: got %b want 0", bus.busy); else n_pass++;
    @(negedge CLK);
    RST_n = 1'b1;
    send_frame(16'h003C, 1'b0, -1, 1'b0);
    n_total++;
    if (bus.P_DATA !== 8'h3C) $display("FAIL rstm_pdata2: got %h want 3c", bus.P_DATA); else n_pass++;
    n_total++;
    if (bus.ovr_err !== 1'b0) $display("FAIL rstm_ovr: got %b want 0", bus.ovr_err); else n_pass++;
    consume();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    bus.clr         = 1'b0;
    bus.bit_vld     = 1'b0;
    bus.sampled_bit = 1'b0;
    bus.msb_first   = 1'b0;
    bus.par_typ     = 1'b0;
    bus.data_rdy    = 1'b0;
    test_reset();
    test_lsb_first();
    test_msb_first();
`ifdef DESER_PARITY_EN
    test_parity();
`endif
    test_overrun();
    test_clr();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rx_deser_unit.md
# rx_deser_unit

Parametrised serial-to-parallel unit for the UART receive path, and the next generation of the receiver's bit collector. It accepts one sampled bit per strobe from the bit-sampling logic and keeps its own bit counter. It supports runtime-selectable bit order and optional parity checking. Completed words go out through a registered valid/ready holding stage with overrun detection, so the frame FSM no longer has to track bit indices.

## Interface
- DATA_W, 8, data bits per frame; legal range 5..16.
- CLK  in  1  clock; all state updates on the rising edge.
- RST_n  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous frame abort; clears collection state.
- bit_vld  in  1  one-cycle strobe: sampled_bit is a valid received bit.
- sampled_bit  in  1  received bit value.
- msb_first  in  1  bit order: 0 = first bit to P_DATA[0] (UART order), 1 = first bit to P_DATA[DATA_W-1].
- par_typ  in  1  0 = even parity, 1 = odd parity; ignored without DESER_PARITY_EN.
- data_rdy  in  1  consumer accepts P_DATA when high with data_vld.
- P_DATA  out  DATA_W  received word; stable while data_vld is high.
- data_vld  out  1  P_DATA holds an unconsumed word.
- par_err  out  1  parity mismatch for the word in P_DATA; qualified by data_vld.
- ovr_err  out  1  one-cycle pulse: a completed word was dropped.
- busy  out  1  a frame is partially collected (bit counter != 0).

## Operation
- Internal state: shift register sh[DATA_W-1:0], bit counter cnt (width $clog2(DATA_W+2)), latched order bit ord, running parity acc.
- FRAME_LEN = DATA_W + 1 with DESER_PARITY_EN; otherwise FRAME_LEN = DATA_W.
- On bit_vld with cnt == 0:
  - latch ord <= msb_first;
  - clear acc and sh before the bit is applied.
  - msb_first changes mid-frame have no effect.
- Data bit k (cnt = k < DATA_W):
  - ord = 0: sh[k] <= sampled_bit;
  - ord = 1: sh[DATA_W-1-k] <= sampled_bit;
  - acc <= acc ^ sampled_bit;
  - cnt increments.
- Parity bit (cnt == DATA_W, only with DESER_PARITY_EN): the frame completes with computed error = acc ^ sampled_bit ^ par_typ. Even parity means data XOR parity bit = 0.
- Frame completion (cnt reaches FRAME_LEN):
  - cnt returns to 0.
  - If data_vld == 0, or data_vld && data_rdy in the same cycle: P_DATA <= assembled word, par_err <= error, data_vld <= 1.
  - Otherwise the word is dropped, ovr_err pulses for 1 cycle, and P_DATA, par_err and data_vld are unchanged.
- Handshake:
  - data_vld && data_rdy consumes the word; data_vld falls next edge unless a new word loads on the same edge.
  - data_vld never falls without data_rdy.
- clr:
  - Sets cnt, sh and acc to 0.
  - The holding stage (P_DATA, data_vld, par_err) is untouched.
  - clr and bit_vld in the same cycle: clr wins and the bit is discarded.
- bit_vld strobes between frames are not filtered: any strobe at cnt == 0 starts a new frame.

## Timing
- Reset values: P_DATA = 0, data_vld = 0, par_err = 0, ovr_err = 0, busy = 0; internal cnt, sh, acc and ord = 0.
- Latency: last bit_vld of a frame in cycle n → P_DATA/data_vld updated at the edge ending cycle n; visible in cycle n+1.
- busy is combinational from cnt: high from the cycle after the first bit until the cycle after the last bit.
- Back-to-back bit_vld on consecutive cycles is legal; maximum throughput is 1 bit/cycle.
- Reset mid-frame: all state clears immediately and asynchronously; a partial frame is lost without ovr_err.
- ovr_err is registered and is high exactly one cycle per dropped word.

## Configuration
- DESER_PARITY_EN defined:
  - the frame carries one parity bit after the data bits;
  - par_err is computed per word;
  - par_typ is used.
- DESER_PARITY_EN undefined:
  - the frame is DATA_W bits;
  - par_err is constant 0;
  - par_typ is unconnected internally;
  - no parity logic is synthesised.
- The port list is identical in both builds.

## Test plan
- DATA_W=8, parity off, msb_first=0, bits 1,0,1,1,0,0,1,0 on consecutive cycles → P_DATA=8'h4D, data_vld=1 the cycle after the 8th bit, busy low again.
- Same bits with msb_first=1 → P_DATA=8'hB2; toggling msb_first after the 3rd bit still yields 8'hB2.
- DESER_PARITY_EN, par_typ=0, data 8'h4D (four ones) with parity bit 0 → par_err=0; repeat with parity bit 1 → par_err=1; par_typ=1 with parity bit 1 → par_err=0.
- data_rdy held 0 and two frames received (0x4D then 0x12) → P_DATA stays 0x4D and ovr_err pulses once on the 2nd completion. Frame 2 completing while data_rdy=1 → 0x12 loads with data_vld held high, no pulse.
- Assert clr after 3 bits, then send a full frame 0xA5 → P_DATA=0xA5. clr coinciding with a bit_vld → that bit is ignored.
- RST_n low after 4 bits, release, send 0x3C → P_DATA=0x3C; all outputs 0 during reset.
